// File: rtl/nmc_qr_arb_pkg.sv
// Purpose: shared nmc query types, arbitration-policy constants and the channel tag type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nmc_qr_arb_pkg;

    // Arbitration policies selectable on nmc_qr_arb
    localparam int ARB_RR    = 0;   // round-robin starting at rr pointer
    localparam int ARB_FIXED = 1;   // channel 0 highest priority

    // Tag wide enough for the largest supported channel count (16)
    localparam int NMC_TAG_W = 4;
    typedef logic [NMC_TAG_W-1:0] nmc_ch_tag_t;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] addr;
    } nmc_qr_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } nmc_qr_resp_t;

endpackage

// File: rtl/nmc_qr_arb_tag_fifo.sv
// Purpose: in-order tag FIFO; ports push/pop with data, full/empty flags and occupancy count.
// Latency: head visible combinationally; a push is visible at the head one cycle later.
// Backpressure: push on full is ignored unless a pop happens in the same cycle.
module nmc_tag_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  pop_dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic         do_push;
    logic         do_pop;

    // Extra MSB on each pointer separates full (MSBs differ) from empty (equal)
    assign empty_o   = (wr_q == rd_q);
    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o   = CW'(wr_q - rd_q);
    assign pop_dat_o = mem[rd_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so pushing into a full FIFO is fine then
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wr_d = do_push ? wr_q + 1'b1 : wr_q;
    assign rd_d = do_pop  ? rd_q + 1'b1 : rd_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/nmc_qr_arb.sv
// Purpose: arbitrates N_CH query channels onto one nmc query port and routes responses back in order.
//          Ports: per-channel req valid/ready/payload, per-channel resp strobe + broadcast payload,
//          nmc push/payload/full, nmc response, outstanding count, sticky orphan error.
// Latency: grant and response routing are combinational (zero cycles).
// Backpressure: no grant while nqr_full or the in-flight limit is reached (unless a response frees a slot).
module nmc_qr_arb
    import nmc_qr_arb_pkg::*;
#(
    parameter int  N_CH            = 4,
    parameter int  MAX_OUTSTANDING = 8,
    parameter int  ARB_MODE        = ARB_RR,
    localparam int OW              = $clog2(MAX_OUTSTANDING + 1),
    localparam int PW              = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        ch_req_valid,
    input  nmc_qr_req_t [N_CH-1:0] ch_req,
    output logic [N_CH-1:0]        ch_req_ready,
    output logic [N_CH-1:0]        ch_resp_valid,
    output nmc_qr_resp_t           ch_resp,
    output logic                   nqr_push,
    output nmc_qr_req_t            nmc_qr_req,
    input  logic                   nqr_full,
    input  nmc_qr_resp_t           nmc_qr_resp,
    output logic [OW-1:0]          outstanding,
    output logic                   err_orphan
);

    logic [PW-1:0] rr_q, rr_d;
    logic          err_orphan_q, err_orphan_d;
    logic          issue_ok;
    logic          found;
    int            gnt_c;
    logic [PW-1:0] gnt_idx;
    logic          tag_full;
    logic          tag_empty;
    logic          resp_pop;
    nmc_ch_tag_t   tag_head;

    // Inputs are gated by reset so nothing transfers while rst is low
    assign issue_ok = rst && (|ch_req_valid) && !nqr_full && (!tag_full || nmc_qr_resp.valid);

    // Pick the valid channel with the smallest distance from the search start
    always_comb begin
        int best;
        int d;
        int start;
        best  = N_CH;
        found = 1'b0;
        gnt_c = 0;
        start = (ARB_MODE == ARB_RR) ? int'(rr_q) : 0;
        for (int c = 0; c < N_CH; c++) begin
            d = c - start;
            if (d < 0) d = d + N_CH;
            if (ch_req_valid[c] && (d < best)) begin
                best  = d;
                gnt_c = c;
                found = 1'b1;
            end
        end
    end

    assign gnt_idx  = PW'(gnt_c);
    assign nqr_push = issue_ok && found;

    always_comb begin
        ch_req_ready = '0;
        nmc_qr_req   = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (nqr_push && (gnt_c == c)) begin
                ch_req_ready[c] = 1'b1;
                nmc_qr_req      = ch_req[c];
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if ((ARB_MODE == ARB_RR) && nqr_push) begin
            rr_d = (gnt_idx == PW'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Response routing: head tag names the owner; an empty FIFO means an orphan
    assign resp_pop = rst && nmc_qr_resp.valid && !tag_empty;
    assign ch_resp  = nmc_qr_resp;

    always_comb begin
        ch_resp_valid = '0;
        for (int c = 0; c < N_CH; c++) begin
            ch_resp_valid[c] = resp_pop && (tag_head == NMC_TAG_W'(c));
        end
    end

    assign err_orphan_d = err_orphan_q || (nmc_qr_resp.valid && tag_empty);
    assign err_orphan   = err_orphan_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q         <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    nmc_tag_fifo #(
        .W     (NMC_TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk_i      (clk),
        .rst_ni     (rst),
        .push_i     (nqr_push),
        .push_dat_i (NMC_TAG_W'(gnt_c)),
        .pop_i      (resp_pop),
        .pop_dat_o  (tag_head),
        .full_o     (tag_full),
        .empty_o    (tag_empty),
        .count_o    (outstanding)
    );

endmodule

// File: doc/nmc_qr_arb.md
NMC_QR_ARB -- requirements
Module: nmc_qr_arb

Interface
REQ-001 Parameter N_CH, default 4, number of independent query channels sharing one nmc query port (2..16).
REQ-002 Parameter MAX_OUTSTANDING, default 8, maximum issued-but-unanswered queries (power of two, 2..64).
REQ-003 Parameter ARB_MODE, default ARB_RR, arbitration policy: ARB_RR round-robin, ARB_FIXED channel 0 highest priority.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 ch_req_valid  in  N_CH  per-channel query request valid.
REQ-007 ch_req  in  N_CH x nmc_qr_req_t  per-channel query payload.
REQ-008 ch_req_ready  out  N_CH  one-hot accept; request transfers when valid and ready are both high.
REQ-009 ch_resp_valid  out  N_CH  one-hot response strobe to the owning channel.
REQ-010 ch_resp  out  nmc_qr_resp_t  response payload, broadcast to all channels.
REQ-011 nqr_push  out  1  push into nmc query FIFO.
REQ-012 nmc_qr_req  out  nmc_qr_req_t  payload of granted channel.
REQ-013 nqr_full  in  1  nmc query FIFO full.
REQ-014 nmc_qr_resp  in  nmc_qr_resp_t  nmc response; .valid marks a response cycle.
REQ-015 outstanding  out  clog2(MAX_OUTSTANDING+1)  current in-flight count.
REQ-016 err_orphan  out  1  sticky: response received with no in-flight tag.

Function
REQ-017 Issue allowed in a cycle iff any ch_req_valid, !nqr_full, and (outstanding < MAX_OUTSTANDING or nmc_qr_resp.valid this cycle).
REQ-018 At most one channel granted per cycle; grant is combinational, zero latency: ch_req_ready[g]=1, nqr_push=1, nmc_qr_req=ch_req[g], payload unmodified.
REQ-019 ch_req_ready never asserted for a channel without ch_req_valid; ch_req_ready all-zero when issue not allowed.
REQ-020 ARB_RR: search starts at rr_ptr, wraps N_CH-1 -> 0; after a grant rr_ptr <= (g+1) mod N_CH; no grant leaves rr_ptr unchanged.
REQ-021 ARB_FIXED: lowest-index valid channel granted; rr_ptr unused.
REQ-022 On issue, granted channel index pushed into an in-order tag FIFO of depth MAX_OUTSTANDING.
REQ-023 On nmc_qr_resp.valid with tag FIFO non-empty: pop head tag t, ch_resp_valid[t]=1 same cycle, ch_resp=nmc_qr_resp; combinational, zero latency.
REQ-024 On nmc_qr_resp.valid with tag FIFO empty: response dropped, ch_resp_valid all-zero, err_orphan <= 1 until reset.
REQ-025 Simultaneous issue and response: push and pop same cycle, outstanding unchanged; permitted also when FIFO full (pop frees slot).
REQ-026 outstanding: +1 on issue only, -1 on valid pop only, unchanged otherwise; never exceeds MAX_OUTSTANDING, never underflows.
REQ-027 FIFO read/write pointers wrap modulo MAX_OUTSTANDING; full/empty distinguished by an extra pointer bit.

Reset
REQ-028 On rst low: ch_req_ready, ch_resp_valid, nqr_push = 0 (inputs gated); outstanding=0; rr_ptr=0; tag FIFO empty; err_orphan=0.
REQ-029 Reset mid-operation discards all in-flight tags; responses arriving after reset release count as orphans.

Structure
REQ-030 ARB_RR/ARB_FIXED constants and nmc_ch_tag_t added to the shared nmc package alongside nmc_qr_req_t/nmc_qr_resp_t.
REQ-031 Tag FIFO implemented as sub-module nmc_tag_fifo (parametrised width/depth, push/pop/full/empty/count); arbiter logic in nmc_qr_arb.

Verification
REQ-032 RR fairness: N_CH=4, all channels valid continuously, responses every cycle -> grants 0,1,2,3,0,... and each channel's ch_resp_valid in issue order.
REQ-033 Credit limit: MAX_OUTSTANDING=8, no responses -> exactly 8 pushes then ready=0 and outstanding=8; one response -> one further issue in that same cycle.
REQ-034 Backpressure: nqr_full=1 for 5 cycles with channel 2 valid -> no nqr_push, ch_req_ready=0, rr_ptr unchanged; issue on first cycle nqr_full=0.
REQ-035 Fixed priority: ARB_FIXED, channels 1 and 3 valid -> channel 1 granted every cycle until it drops, then channel 3.
REQ-036 Orphan: nmc_qr_resp.valid with outstanding=0 -> no ch_resp_valid, err_orphan=1 and held; clears only on rst low.
REQ-037 Reset mid-op: 3 outstanding, rst pulsed low -> outstanding=0, rr_ptr=0; next 3 responses flag err_orphan.
